// File: rtl/rd_flag_ctrl.sv
// Read-domain pointer and status controller for the async FIFO.
// Keeps the binary/Gray read pointer, synchronises the write-side Gray
// pointer and produces look-ahead EMPTY, ALMOST_EMPTY, fill level and a
// sticky UNDERFLOW flag.
module rd_flag_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  READ_ENA,
    input  logic [ADDR_WIDTH:0]   WRITE_PTR_GRAY,
    input  logic [ADDR_WIDTH:0]   AE_LEVEL,
    input  logic                  CLR_UNDERFLOW,
    output logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic [ADDR_WIDTH:0]   READ_PTR_GRAY,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   RD_LEVEL,
    output logic                  UNDERFLOW
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0] wsync_gray;
    logic [PW-1:0] wsync_bin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] level_next;
    logic          rd_fire;
    logic          underflow_next;

    // Write-pointer synchroniser chain; stage 0 samples the foreign-domain bus
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], WRITE_PTR_GRAY};
        end
    end

    assign wsync_gray = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        wsync_bin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wsync_bin[i] = ^(wsync_gray >> i);
        end
    end

    // Next-state pointer, level and flag equations shared by read and write updates
    always_comb begin
        rd_fire        = READ_ENA & ~EMPTY;
        rbin_next      = rbin + PW'(rd_fire);
        rgray_next     = rbin_next ^ (rbin_next >> 1);
        level_next     = wsync_bin - rbin_next;
        underflow_next = UNDERFLOW;
        if (READ_ENA && EMPTY) begin
            underflow_next = 1'b1;
        end else if (CLR_UNDERFLOW) begin
            underflow_next = 1'b0;
        end
    end

    // Registered pointer and status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rbin          <= '0;
            READ_PTR_GRAY <= '0;
            EMPTY         <= 1'b1;
            ALMOST_EMPTY  <= 1'b1;
            RD_LEVEL      <= '0;
            UNDERFLOW     <= 1'b0;
        end else begin
            rbin          <= rbin_next;
            READ_PTR_GRAY <= rgray_next;
            EMPTY         <= (rgray_next == wsync_gray);
            ALMOST_EMPTY  <= (level_next <= AE_LEVEL);
            RD_LEVEL      <= level_next;
            UNDERFLOW     <= underflow_next;
        end
    end

    assign RD_ADDR = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_rd_flag_ctrl.sv
// Scoreboard bench for rd_flag_ctrl (ADDR_WIDTH = 4, SYNC_STAGES = 2).
// Stimulus pushes cycle-tagged expectations; a negedge monitor pops and compares.
module tb_rd_flag_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;

    localparam int S_EMPTY = 0;
    localparam int S_AE    = 1;
    localparam int S_LEVEL = 2;
    localparam int S_ADDR  = 3;
    localparam int S_RGRAY = 4;
    localparam int S_UF    = 5;

    logic          CLK;
    logic          RST_N;
    logic          READ_ENA;
    logic [PW-1:0] WRITE_PTR_GRAY;
    logic [PW-1:0] AE_LEVEL;
    logic          CLR_UNDERFLOW;
    logic [AW-1:0] RD_ADDR;
    logic [PW-1:0] READ_PTR_GRAY;
    logic          EMPTY;
    logic          ALMOST_EMPTY;
    logic [PW-1:0] RD_LEVEL;
    logic          UNDERFLOW;

    rd_flag_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .READ_ENA       (READ_ENA),
        .WRITE_PTR_GRAY (WRITE_PTR_GRAY),
        .AE_LEVEL       (AE_LEVEL),
        .CLR_UNDERFLOW  (CLR_UNDERFLOW),
        .RD_ADDR        (RD_ADDR),
        .READ_PTR_GRAY  (READ_PTR_GRAY),
        .EMPTY          (EMPTY),
        .ALMOST_EMPTY   (ALMOST_EMPTY),
        .RD_LEVEL       (RD_LEVEL),
        .UNDERFLOW      (UNDERFLOW)
    );

    typedef struct {
        int    cyc;
        int    sig;
        int    exp;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   act;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    function automatic int get_sig(int s);
        case (s)
            S_EMPTY: return int'(EMPTY);
            S_AE:    return int'(ALMOST_EMPTY);
            S_LEVEL: return int'(RD_LEVEL);
            S_ADDR:  return int'(RD_ADDR);
            S_RGRAY: return int'(READ_PTR_GRAY);
            default: return int'(UNDERFLOW);
        endcase
    endfunction

    // Monitor: compare every expectation tagged for the current cycle
    always @(negedge CLK) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                n_checks++;
                act = get_sig(sb_q[i].sig);
                if (act != sb_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                             sb_q[i].name, act, sb_q[i].exp, cyc);
                end
                sb_q.delete(i);
            end else if (sb_q[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d never sampled",
                         sb_q[i].name, sb_q[i].cyc);
                sb_q.delete(i);
            end
        end
    end

    task automatic chk(input int ahead, input int s, input int v, input string nm);
        exp_t e;
        e.cyc  = cyc + ahead;
        e.sig  = s;
        e.exp  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic chk_reset(input string nm);
        chk(0, S_EMPTY, 1, {nm, "_empty"});
        chk(0, S_AE,    1, {nm, "_ae"});
        chk(0, S_LEVEL, 0, {nm, "_level"});
        chk(0, S_ADDR,  0, {nm, "_addr"});
        chk(0, S_RGRAY, 0, {nm, "_rgray"});
        chk(0, S_UF,    0, {nm, "_uf"});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_wr(input int b);
        logic [PW-1:0] bb;
        bb = PW'(b);
        WRITE_PTR_GRAY = bb ^ (bb >> 1);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N          = 1'b0;
        READ_ENA       = 1'b0;
        WRITE_PTR_GRAY = '0;
        AE_LEVEL       = PW'(1);
        CLR_UNDERFLOW  = 1'b0;

        // Reset state
        tick(2);
        chk_reset("reset");
        tick(1);
        RST_N = 1'b1;
        tick(2);

        // Sync latency: pointer 0 -> 1 visible on the third edge
        set_wr(1);
        chk(1, S_EMPTY, 1, "sync_e1");
        chk(2, S_EMPTY, 1, "sync_e2");
        chk(3, S_EMPTY, 0, "sync_e3");
        chk(3, S_LEVEL, 1, "sync_level");
        chk(3, S_AE,    1, "sync_ae");
        tick(3);

        // Look-ahead empty: write pointer settles at 3
        set_wr(2);
        tick(1);
        set_wr(3);
        tick(3);
        chk(0, S_LEVEL, 3, "la_level0");
        chk(0, S_AE,    0, "la_ae0");
        chk(0, S_ADDR,  0, "la_addr0");
        READ_ENA = 1'b1;
        chk(1, S_ADDR,  1, "la_addr1");
        chk(1, S_LEVEL, 2, "la_level1");
        chk(1, S_AE,    0, "la_ae1");
        chk(2, S_ADDR,  2, "la_addr2");
        chk(2, S_LEVEL, 1, "la_level2");
        chk(2, S_AE,    1, "la_ae2");
        chk(2, S_EMPTY, 0, "la_empty2");
        chk(3, S_ADDR,  3, "la_addr3");
        chk(3, S_LEVEL, 0, "la_level3");
        chk(3, S_EMPTY, 1, "la_empty3");
        chk(3, S_UF,    0, "la_uf3");
        chk(4, S_ADDR,  3, "la_addr4_hold");
        chk(4, S_RGRAY, 2, "la_rgray4");
        chk(4, S_UF,    1, "uf_set");
        tick(4);

        // Underflow: set wins over clear, then clear alone
        CLR_UNDERFLOW = 1'b1;
        chk(1, S_UF,   1, "uf_set_wins");
        chk(1, S_ADDR, 3, "uf_ptr_hold");
        tick(1);
        READ_ENA = 1'b0;
        chk(1, S_UF, 0, "uf_clear");
        tick(1);
        CLR_UNDERFLOW = 1'b0;

        // Full depth and wrap, from a fresh reset
        RST_N = 1'b0;
        WRITE_PTR_GRAY = '0;
        tick(2);
        RST_N = 1'b1;
        for (int b = 1; b <= 16; b++) begin
            set_wr(b);
            tick(1);
        end
        tick(3);
        chk(0, S_LEVEL, 16, "full_level");
        chk(0, S_EMPTY, 0,  "full_empty");
        chk(0, S_AE,    0,  "full_ae");
        READ_ENA = 1'b1;
        chk(8,  S_ADDR,  8,    "wrap_addr8");
        chk(8,  S_LEVEL, 8,    "wrap_level8");
        chk(15, S_ADDR,  15,   "wrap_addr15");
        chk(15, S_LEVEL, 1,    "wrap_level15");
        chk(16, S_ADDR,  0,    "wrap_addr16");
        chk(16, S_RGRAY, 5'b11000, "wrap_rgray");
        chk(16, S_EMPTY, 1,    "wrap_empty");
        chk(16, S_LEVEL, 0,    "wrap_level16");
        chk(16, S_UF,    0,    "wrap_uf");
        tick(16);
        READ_ENA = 1'b0;
        for (int b = 17; b <= 20; b++) begin
            set_wr(b);
            tick(1);
        end
        tick(3);
        chk(0, S_LEVEL, 4, "wrap_level_after");
        chk(0, S_EMPTY, 0, "wrap_empty_after");

        // Concurrent: level 5, one read and one write per cycle
        set_wr(21);
        tick(3);
        chk(0, S_LEVEL, 5, "conc_level_start");
        for (int j = 0; j <= 21; j++) begin
            set_wr(22 + j);
            READ_ENA = (j >= 2);
            chk(1, S_LEVEL, 5, "conc_level");
            chk(1, S_EMPTY, 0, "conc_empty");
            chk(1, S_UF,    0, "conc_uf");
            tick(1);
        end
        READ_ENA = 1'b0;
        tick(4);
        chk(0, S_LEVEL, 7, "conc_level_end");
        chk(0, S_ADDR,  4, "conc_addr_end");

        // Reset pulse between edges during a read burst
        READ_ENA = 1'b1;
        tick(2);
        #1;
        RST_N    = 1'b0;
        READ_ENA = 1'b0;
        chk_reset("rst_pulse");
        #5;
        RST_N = 1'b1;
        chk(3, S_LEVEL, 11, "post_rst_level");
        chk(3, S_EMPTY, 0,  "post_rst_empty");
        chk(3, S_ADDR,  0,  "post_rst_addr");
        tick(6);

        while (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation left unchecked", sb_q[0].name);
            void'(sb_q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
